// File: rtl/corr_pkg.sv
// corr_pkg: shared definitions for the correlation frame sequencer.
//   corr_state_t  - sequencer FSM states
//   FFT_CFG_DEF   - default FFT_CONFIG word (forward transform)
//   IFFT_CFG_DEF  - default IFFT_CONFIG word (inverse transform, scale schedule)
package corr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG_FFT,
        CFG_IFFT,
        SEND_SF,
        SEND_SIG,
        FINISH
    } corr_state_t;

    localparam logic [15:0] FFT_CFG_DEF  = 16'h0001;
    localparam logic [23:0] IFFT_CFG_DEF = 24'h00000A;

endpackage

// File: rtl/corr_seq_ram.sv
// corr_seq_ram: simple dual-port sample memory, one write port and one
// synchronous read port.
//   clk, rst      - clock, async active-high reset (read register only)
//   we/waddr/wdata - write port
//   re/raddr      - read request; rdata updates on the next edge when re=1
//                   and holds otherwise, which the streamer relies on to keep
//                   tdata stable under back-pressure.
module corr_seq_ram #(
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    // Array kept out of the reset domain so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/corr_frame_sequencer.sv
// corr_frame_sequencer: configures an FFT/IFFT pair, then streams a reference
// frame (S_AXIS_SF) followed by one or more signal frames (S_AXIS_RE/IM).
//   aclk, areset          - clock, async active-high reset
//   start/continuous/stop - sequence control
//   wr_*                  - sample memory load port (IDLE only), wr_err on misuse
//   FFT_CONFIG_*, IFFT_CONFIG_* - one config word each per sequence
//   S_AXIS_SF_*           - reference stream, {re,im} packed
//   S_AXIS_RE/IM_*        - signal stream, shared valid/last
//   busy, done, frame_cnt - status
module corr_frame_sequencer import corr_pkg::*; #(
    parameter int          DATA_W   = 16,
    parameter int          LOG2_N   = 10,
    parameter logic [15:0] FFT_CFG  = FFT_CFG_DEF,
    parameter logic [23:0] IFFT_CFG = IFFT_CFG_DEF
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                start,
    input  logic                continuous,
    input  logic                stop,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [LOG2_N-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_re,
    input  logic [DATA_W-1:0]   wr_im,
    output logic                wr_err,
    output logic [15:0]         FFT_CONFIG_tdata,
    output logic                FFT_CONFIG_tvalid,
    input  logic                FFT_CONFIG_tready,
    output logic [23:0]         IFFT_CONFIG_tdata,
    output logic                IFFT_CONFIG_tvalid,
    input  logic                IFFT_CONFIG_tready,
    output logic [2*DATA_W-1:0] S_AXIS_SF_tdata,
    output logic                S_AXIS_SF_tvalid,
    output logic                S_AXIS_SF_tlast,
    input  logic                S_AXIS_SF_tready,
    output logic [DATA_W-1:0]   S_AXIS_RE_tdata,
    output logic [DATA_W-1:0]   S_AXIS_IM_tdata,
    output logic                S_AXIS_tvalid,
    output logic                S_AXIS_tlast,
    input  logic                S_AXIS_RE_tready,
    input  logic                S_AXIS_IM_tready,
    output logic                busy,
    output logic                done,
    output logic [15:0]         frame_cnt
);

    localparam logic [LOG2_N-1:0] LAST_IDX = '1;

    corr_state_t         state, state_nxt;
    logic                vld;          // a fetched beat is on the active stream
    logic [LOG2_N-1:0]   cnt;          // index of the beat being presented
    logic                stop_lat;
    logic                rd_en;
    logic [LOG2_N-1:0]   rd_addr;
    logic [2*DATA_W-1:0] ref_q, sig_q;
    logic                in_stream, beat_hs, last_beat, sf_hs, sig_hs;

    corr_seq_ram #(.ADDR_W(LOG2_N), .WIDTH(2*DATA_W)) u_ref_ram (
        .clk   (aclk),
        .rst   (areset),
        .we    (wr_en && !wr_sel && state == IDLE),
        .waddr (wr_addr),
        .wdata ({wr_re, wr_im}),
        .re    (rd_en && state == SEND_SF),
        .raddr (rd_addr),
        .rdata (ref_q)
    );

    corr_seq_ram #(.ADDR_W(LOG2_N), .WIDTH(2*DATA_W)) u_sig_ram (
        .clk   (aclk),
        .rst   (areset),
        .we    (wr_en && wr_sel && state == IDLE),
        .waddr (wr_addr),
        .wdata ({wr_re, wr_im}),
        .re    (rd_en && state == SEND_SIG),
        .raddr (rd_addr),
        .rdata (sig_q)
    );

    // Stream outputs are gated by vld so they read as zero whenever idle or
    // in reset; while stalled, rd_en stays low so the RAM output holds.
    assign S_AXIS_SF_tvalid = vld && state == SEND_SF;
    assign S_AXIS_SF_tlast  = S_AXIS_SF_tvalid && cnt == LAST_IDX;
    assign S_AXIS_SF_tdata  = S_AXIS_SF_tvalid ? ref_q : '0;
    assign S_AXIS_tvalid    = vld && state == SEND_SIG;
    assign S_AXIS_tlast     = S_AXIS_tvalid && cnt == LAST_IDX;
    assign S_AXIS_RE_tdata  = S_AXIS_tvalid ? sig_q[2*DATA_W-1:DATA_W] : '0;
    assign S_AXIS_IM_tdata  = S_AXIS_tvalid ? sig_q[DATA_W-1:0] : '0;

    assign sf_hs     = S_AXIS_SF_tvalid && S_AXIS_SF_tready;
    assign sig_hs    = S_AXIS_tvalid && S_AXIS_RE_tready && S_AXIS_IM_tready;
    assign in_stream = state == SEND_SF || state == SEND_SIG;
    assign beat_hs   = sf_hs || sig_hs;
    assign last_beat = vld && cnt == LAST_IDX;
    assign busy      = state != IDLE;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        rd_en              = 1'b0;
        rd_addr            = cnt + 1'b1;
        done               = 1'b0;
        FFT_CONFIG_tvalid  = 1'b0;
        FFT_CONFIG_tdata   = '0;
        IFFT_CONFIG_tvalid = 1'b0;
        IFFT_CONFIG_tdata  = '0;

        // Prefetch beat 0 on entry (one cycle to first tvalid), then fetch
        // the next address on each accepted beat for one beat per cycle.
        if (in_stream) begin
            if (!vld) begin
                rd_en   = 1'b1;
                rd_addr = '0;
            end else if (beat_hs && cnt != LAST_IDX) begin
                rd_en = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (start)
                    state_nxt = CFG_FFT;
            end
            CFG_FFT: begin
                FFT_CONFIG_tvalid = 1'b1;
                FFT_CONFIG_tdata  = FFT_CFG;
                if (FFT_CONFIG_tready)
                    state_nxt = CFG_IFFT;
            end
            CFG_IFFT: begin
                IFFT_CONFIG_tvalid = 1'b1;
                IFFT_CONFIG_tdata  = IFFT_CFG;
                if (IFFT_CONFIG_tready)
                    state_nxt = SEND_SF;
            end
            SEND_SF: begin
                if (last_beat && sf_hs)
                    state_nxt = SEND_SIG;
            end
            SEND_SIG: begin
                // A stop arriving on the final beat itself also ends the run.
                if (last_beat && sig_hs)
                    state_nxt = (continuous && !stop_lat && !stop) ? SEND_SIG : FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld       <= 1'b0;
            cnt       <= '0;
            stop_lat  <= 1'b0;
            frame_cnt <= '0;
            wr_err    <= 1'b0;
        end else begin
            wr_err <= wr_en && state != IDLE;

            if (rd_en) begin
                vld <= 1'b1;
                cnt <= rd_addr;
            end else if (in_stream && last_beat && beat_hs) begin
                vld <= 1'b0;
            end

            if (state == IDLE)
                stop_lat <= 1'b0;
            else if (state == SEND_SIG && stop)
                stop_lat <= 1'b1;

            if (state == IDLE && start)
                frame_cnt <= '0;
            else if (state == SEND_SIG && last_beat && sig_hs)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_corr_frame_sequencer.sv
// Scoreboard bench for corr_frame_sequencer: stimulus pushes expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_corr_frame_sequencer;

    localparam int DW = 16;
    localparam int LN = 10;
    localparam int N  = 1 << LN;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic start = 1'b0, continuous = 1'b0, stop = 1'b0;
    logic wr_en = 1'b0, wr_sel = 1'b0;
    logic [LN-1:0] wr_addr = '0;
    logic [DW-1:0] wr_re = '0, wr_im = '0;
    logic wr_err;
    logic [15:0] FFT_CONFIG_tdata;
    logic FFT_CONFIG_tvalid, FFT_CONFIG_tready = 1'b1;
    logic [23:0] IFFT_CONFIG_tdata;
    logic IFFT_CONFIG_tvalid, IFFT_CONFIG_tready = 1'b1;
    logic [2*DW-1:0] S_AXIS_SF_tdata;
    logic S_AXIS_SF_tvalid, S_AXIS_SF_tlast, S_AXIS_SF_tready = 1'b1;
    logic [DW-1:0] S_AXIS_RE_tdata, S_AXIS_IM_tdata;
    logic S_AXIS_tvalid, S_AXIS_tlast;
    logic S_AXIS_RE_tready = 1'b1, S_AXIS_IM_tready = 1'b1;
    logic busy, done;
    logic [15:0] frame_cnt;

    always #5 aclk = ~aclk;

    corr_frame_sequencer #(.DATA_W(DW), .LOG2_N(LN)) dut (
        .aclk(aclk), .areset(areset), .start(start), .continuous(continuous), .stop(stop),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_re(wr_re), .wr_im(wr_im),
        .wr_err(wr_err),
        .FFT_CONFIG_tdata(FFT_CONFIG_tdata), .FFT_CONFIG_tvalid(FFT_CONFIG_tvalid),
        .FFT_CONFIG_tready(FFT_CONFIG_tready),
        .IFFT_CONFIG_tdata(IFFT_CONFIG_tdata), .IFFT_CONFIG_tvalid(IFFT_CONFIG_tvalid),
        .IFFT_CONFIG_tready(IFFT_CONFIG_tready),
        .S_AXIS_SF_tdata(S_AXIS_SF_tdata), .S_AXIS_SF_tvalid(S_AXIS_SF_tvalid),
        .S_AXIS_SF_tlast(S_AXIS_SF_tlast), .S_AXIS_SF_tready(S_AXIS_SF_tready),
        .S_AXIS_RE_tdata(S_AXIS_RE_tdata), .S_AXIS_IM_tdata(S_AXIS_IM_tdata),
        .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tlast(S_AXIS_tlast),
        .S_AXIS_RE_tready(S_AXIS_RE_tready), .S_AXIS_IM_tready(S_AXIS_IM_tready),
        .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t       exp_sf[$];
    beat_t       exp_sig[$];
    logic [15:0] exp_fft[$];
    logic [23:0] exp_ifft[$];

    int checks = 0, failures = 0;
    int sf_beat = 0, sig_beat = 0, sig_frames = 0, done_cnt = 0;
    int mode = 0;
    bit fft_hold = 1'b0;

    logic        pv_sf = 0, pr_sf = 0, pv_sig = 0, pr_sig = 0, prev_done = 0;
    logic [32:0] pd_sf = '0, pd_sig = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Ready pattern generator: mode 0 all ready, mode 1 stall pattern.
    always begin
        @(posedge aclk);
        #1;
        FFT_CONFIG_tready  = !fft_hold;
        IFFT_CONFIG_tready = 1'b1;
        S_AXIS_IM_tready   = 1'b1;
        if (mode == 1) begin
            S_AXIS_SF_tready = ~S_AXIS_SF_tready;
            S_AXIS_RE_tready = 1'($urandom_range(0, 1));
        end else begin
            S_AXIS_SF_tready = 1'b1;
            S_AXIS_RE_tready = 1'b1;
        end
    end

    // Monitor / scoreboard
    always @(negedge aclk) begin
        beat_t e;
        if (areset) begin
            exp_sf.delete(); exp_sig.delete(); exp_fft.delete(); exp_ifft.delete();
            sf_beat = 0; sig_beat = 0;
            pv_sf = 0; pr_sf = 0; pv_sig = 0; pr_sig = 0; prev_done = 0;
        end else begin
            if (FFT_CONFIG_tvalid && FFT_CONFIG_tready) begin
                chk("fft_expected", 64'(exp_fft.size() != 0), 1);
                if (exp_fft.size() != 0) chk("fft_cfg", 64'(FFT_CONFIG_tdata), 64'(exp_fft.pop_front()));
            end
            if (IFFT_CONFIG_tvalid && IFFT_CONFIG_tready) begin
                chk("ifft_expected", 64'(exp_ifft.size() != 0), 1);
                if (exp_ifft.size() != 0) chk("ifft_cfg", 64'(IFFT_CONFIG_tdata), 64'(exp_ifft.pop_front()));
            end
            if (pv_sf && !pr_sf) begin
                chk("sf_hold_valid", 64'(S_AXIS_SF_tvalid), 1);
                chk("sf_hold_data", 64'({S_AXIS_SF_tdata, S_AXIS_SF_tlast}), 64'(pd_sf));
            end
            if (pv_sig && !pr_sig) begin
                chk("sig_hold_valid", 64'(S_AXIS_tvalid), 1);
                chk("sig_hold_data", 64'({S_AXIS_RE_tdata, S_AXIS_IM_tdata, S_AXIS_tlast}), 64'(pd_sig));
            end
            if (S_AXIS_SF_tvalid && S_AXIS_SF_tready) begin
                chk("sf_expected", 64'(exp_sf.size() != 0), 1);
                if (exp_sf.size() != 0) begin
                    e = exp_sf.pop_front();
                    chk("sf_data", 64'(S_AXIS_SF_tdata), 64'(e.d));
                    chk("sf_last", 64'(S_AXIS_SF_tlast), 64'(e.l));
                end
                sf_beat = S_AXIS_SF_tlast ? 0 : sf_beat + 1;
            end
            if (S_AXIS_tvalid && S_AXIS_RE_tready && S_AXIS_IM_tready) begin
                chk("sig_expected", 64'(exp_sig.size() != 0), 1);
                if (exp_sig.size() != 0) begin
                    e = exp_sig.pop_front();
                    chk("sig_data", 64'({S_AXIS_RE_tdata, S_AXIS_IM_tdata}), 64'(e.d));
                    chk("sig_last", 64'(S_AXIS_tlast), 64'(e.l));
                end
                if (S_AXIS_tlast) begin
                    sig_beat = 0;
                    sig_frames++;
                end else begin
                    sig_beat++;
                end
            end
            if (done) begin
                chk("done_one_cycle", 64'(prev_done), 0);
                done_cnt++;
            end
            pv_sf = S_AXIS_SF_tvalid; pr_sf = S_AXIS_SF_tready;
            pd_sf = {S_AXIS_SF_tdata, S_AXIS_SF_tlast};
            pv_sig = S_AXIS_tvalid; pr_sig = S_AXIS_RE_tready && S_AXIS_IM_tready;
            pd_sig = {S_AXIS_RE_tdata, S_AXIS_IM_tdata, S_AXIS_tlast};
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic load_all();
        for (int k = 0; k < N; k++) begin
            wr_en = 1'b1; wr_addr = LN'(k);
            wr_sel = 1'b0; wr_re = 16'(k); wr_im = ~16'(k);
            tick();
            wr_sel = 1'b1; wr_re = 16'(k + 1); wr_im = 16'(k);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic push_seq(input int frames);
        logic [15:0] kk;
        exp_fft.push_back(16'h0001);
        exp_ifft.push_back(24'h00000A);
        for (int k = 0; k < N; k++) begin
            kk = 16'(k);
            exp_sf.push_back('{d: {kk, ~kk}, l: (k == N - 1)});
        end
        for (int f = 0; f < frames; f++)
            for (int k = 0; k < N; k++) begin
                kk = 16'(k);
                exp_sig.push_back('{d: {kk + 16'd1, kk}, l: (k == N - 1)});
            end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int exp_frames);
        int c0 = done_cnt;
        int n = 0;
        while (done_cnt == c0 && n < 30000) begin
            tick();
            n++;
        end
        chk({nm, "_done_seen"}, 64'(done_cnt != c0), 1);
        chk({nm, "_busy_after"}, 64'(busy), 0);
        chk({nm, "_done_after"}, 64'(done), 0);
        chk({nm, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
        chk({nm, "_left_sf"}, 64'(exp_sf.size()), 0);
        chk({nm, "_left_sig"}, 64'(exp_sig.size()), 0);
        chk({nm, "_left_cfg"}, 64'(exp_fft.size() + exp_ifft.size()), 0);
    endtask

    task automatic wait_sig(input string nm, input int fr, input int beat);
        int n = 0;
        while (!(sig_frames == fr && sig_beat == beat) && n < 20000) begin
            tick();
            n++;
        end
        chk({nm, "_reached"}, 64'(sig_frames == fr && sig_beat == beat), 1);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_cfg"}, 64'({FFT_CONFIG_tvalid, FFT_CONFIG_tdata, IFFT_CONFIG_tvalid, IFFT_CONFIG_tdata}), 0);
        chk({nm, "_sf"}, 64'({S_AXIS_SF_tvalid, S_AXIS_SF_tlast, S_AXIS_SF_tdata}), 0);
        chk({nm, "_sig"}, 64'({S_AXIS_tvalid, S_AXIS_tlast, S_AXIS_RE_tdata, S_AXIS_IM_tdata}), 0);
        chk({nm, "_status"}, 64'({busy, done, wr_err, frame_cnt}), 0);
    endtask

    initial begin
        int base;
        repeat (2) @(posedge aclk);
        #1;
        check_idle("reset");
        areset = 1'b0;
        tick();
        load_all();

        // Basic single frame, always ready
        push_seq(1);
        do_start();
        chk("start_busy", 64'(busy), 1);
        wait_done("basic", 1);

        // Back-pressure on both streams
        mode = 1;
        push_seq(1);
        do_start();
        wait_done("stall", 1);
        mode = 0;
        tick();

        // Continuous run, stop during frame 3
        continuous = 1'b1;
        push_seq(3);
        base = sig_frames;
        do_start();
        wait_sig("cont_beat500", base + 2, 500);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("cont", 3);
        continuous = 1'b0;

        // Reset in the middle of the signal frame
        push_seq(1);
        base = sig_frames;
        do_start();
        chk("restart_frame_cnt_clr", 64'(frame_cnt), 0);
        wait_sig("rst_beat300", base, 300);
        areset = 1'b1;
        #1;
        check_idle("midreset");
        tick();
        areset = 1'b0;
        tick();
        check_idle("post_reset");
        load_all();
        push_seq(1);
        do_start();
        wait_done("after_reset", 1);

        // Write and start while busy are both ignored
        push_seq(1);
        do_start();
        begin
            int n = 0;
            while (sf_beat != 10 && n < 5000) begin
                tick();
                n++;
            end
            chk("sf_beat10_reached", 64'(sf_beat), 10);
        end
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = LN'(5); wr_re = 16'hDEAD; wr_im = 16'hBEEF;
        start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        chk("wr_err_pulse", 64'(wr_err), 1);
        tick();
        chk("wr_err_clear", 64'(wr_err), 0);
        wait_done("busy_wr", 1);

        // FFT config held off; also re-reads memory to prove the write was dropped
        fft_hold = 1'b1;
        tick();
        push_seq(1);
        do_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            chk("cfg_hold", 64'({FFT_CONFIG_tvalid, FFT_CONFIG_tdata, S_AXIS_SF_tvalid}), 64'({1'b1, 16'h0001, 1'b0}));
        end
        tick();
        fft_hold = 1'b0;
        wait_done("cfg_hold", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/corr_frame_sequencer.md
CORR_FRAME_SEQUENCER -- requirements
Module: corr_frame_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, 16: width of each RE/IM sample.
REQ-002 SHALL have parameter LOG2_N, 10: frame length N = 2^LOG2_N samples.
REQ-003 SHALL have parameter FFT_CFG, 16'h0001: word sent on FFT_CONFIG (forward transform).
REQ-004 SHALL have parameter IFFT_CFG, 24'h00000A: word sent on IFFT_CONFIG (inverse transform, scale schedule).
REQ-005 SHALL have ports: aclk in 1, single clock; areset in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: start in 1, frame-sequence start pulse; continuous in 1, repeat signal frames until stop; stop in 1, end continuous run after the current frame.
REQ-007 SHALL have ports: wr_en in 1; wr_sel in 1 (0 = reference, 1 = signal); wr_addr in LOG2_N; wr_re in DATA_W; wr_im in DATA_W; wr_err out 1.
REQ-008 SHALL have ports: FFT_CONFIG_tdata out 16, FFT_CONFIG_tvalid out 1, FFT_CONFIG_tready in 1; IFFT_CONFIG_tdata out 24, IFFT_CONFIG_tvalid out 1, IFFT_CONFIG_tready in 1.
REQ-009 SHALL have ports: S_AXIS_SF_tdata out 2*DATA_W ({re,im}), S_AXIS_SF_tvalid out 1, S_AXIS_SF_tlast out 1, S_AXIS_SF_tready in 1.
REQ-010 SHALL have ports: S_AXIS_RE_tdata out DATA_W, S_AXIS_IM_tdata out DATA_W, S_AXIS_tvalid out 1 (shared by RE/IM), S_AXIS_tlast out 1, S_AXIS_RE_tready in 1, S_AXIS_IM_tready in 1.
REQ-011 SHALL have ports: busy out 1; done out 1, one-cycle pulse; frame_cnt out 16, signal frames completed since start.

Function
REQ-012 SHALL implement states IDLE, CFG_FFT, CFG_IFFT, SEND_SF, SEND_SIG, FINISH.
REQ-013 IDLE: start=1 -> CFG_FFT, frame_cnt cleared to 0, busy=1 from the next cycle.
REQ-014 CFG_FFT: drive FFT_CONFIG_tdata=FFT_CFG with tvalid=1 until the tvalid&&tready cycle, then CFG_IFFT; CFG_IFFT likewise with IFFT_CFG, then SEND_SF.
REQ-015 SEND_SF: stream reference memory entries 0..N-1 in address order; tlast=1 on beat N-1 only; on the handshake of beat N-1 -> SEND_SIG.
REQ-016 SEND_SIG: stream signal memory entries 0..N-1 on RE/IM; handshake = S_AXIS_tvalid && RE_tready && IM_tready; tlast on beat N-1; frame_cnt increments on the final handshake.
REQ-017 After the last signal beat: continuous=1 and no latched stop -> SEND_SIG again from address 0; otherwise -> FINISH.
REQ-018 A stop pulse at any point in SEND_SIG SHALL be latched and honoured at that frame's end; the frame is never truncated.
REQ-019 FINISH: done=1 for one cycle, then IDLE with busy=0.
REQ-020 All AXI outputs: tdata/tlast SHALL be stable while tvalid=1 and tready=0; tvalid SHALL not drop before handshake.
REQ-021 With tready held high, a stream SHALL deliver one beat per cycle; first tvalid no later than 2 cycles after state entry.
REQ-022 Memory write: wr_en in IDLE writes {wr_re,wr_im} to the selected memory at wr_addr; wr_en while busy SHALL be ignored and SHALL pulse wr_err for one cycle.
REQ-023 start while busy SHALL be ignored; start and wr_en together in IDLE: write performed, then sequence starts.
REQ-024 frame_cnt SHALL wrap from 16'hFFFF to 0.

Reset
REQ-025 areset=1 SHALL immediately force IDLE, all tvalid/tlast/busy/done/wr_err=0, all tdata=0, frame_cnt=0, stop latch cleared.
REQ-026 Reset mid-stream SHALL abort the frame; memory contents need not be preserved.

Structure
REQ-027 State enum and default FFT_CFG/IFFT_CFG values SHALL live in shared package corr_pkg.
REQ-028 Both sample memories SHALL be instances of sub-module corr_seq_ram (1 write, 1 synchronous read port, depth N, width 2*DATA_W).

Verification
REQ-029 Load ref[k]={k,~k}, sig[k]={k+1,k}, N=1024, start, tready=1 -> FFT cfg 16'h0001, IFFT cfg 24'h00000A, 1024 SF beats then 1024 RE/IM beats in order, tlast on beat 1023 each, done pulse, frame_cnt=1.
REQ-030 SF_tready toggled 1-0 every cycle and RE_tready random -> data stable under stall, no beat lost or duplicated.
REQ-031 continuous=1, stop pulsed at signal beat 500 of frame 3 -> frame 3 completes, frame_cnt=3, done pulse.
REQ-032 areset asserted at signal beat 300 -> all outputs 0 same cycle, IDLE; new start runs full sequence.
REQ-033 wr_en during SEND_SF -> wr_err pulse, memory unchanged; start while busy -> no effect.
REQ-034 FFT_CONFIG_tready held 0 for 50 cycles -> tvalid stays 1, tdata 16'h0001, no SF traffic until handshake.
